// File: rtl/prbs_chk23_if.sv
// Word stream and BER report bundle between a PRBS23 stream source and prbs_chk23.
// The master drives received words and the clear request, and the slave returns per-word results.
interface prbs_chk23_if #(
  parameter int pDAT_W = 1
) ();
  localparam int cERR_W = $clog2(pDAT_W + 1);

  logic              ival;
  logic [pDAT_W-1:0] idat;
  logic              iclr;
  logic              oval;
  logic              olock;
  logic [cERR_W-1:0] oerr_bits;
  logic [31:0]       oerr_cnt;
  logic [47:0]       obit_cnt;

  modport master (
    output ival, idat, iclr,
    input  oval, olock, oerr_bits, oerr_cnt, obit_cnt
  );

  modport slave (
    input  ival, idat, iclr,
    output oval, olock, oerr_bits, oerr_cnt, obit_cnt
  );
endinterface

// File: rtl/prbs_chk23.sv
// Self-synchronising checker for the inverted x^23 + x^18 + 1 PRBS stream.
// It acquires lock, free-runs a local reference, and reports per-word and cumulative error counts.
module prbs_chk23 #(
  parameter int pDAT_W     = 1,
  parameter int pMSB_FIRST = 0,
  parameter int pLOCK_BITS = 64,
  parameter int pLOSS_WIN  = 16,
  parameter int pLOSS_ERR  = 32
) (
  input  logic          iclk,
  input  logic          ireset,
  input  logic          iclkena,
  prbs_chk23_if.slave   bus
);
  localparam int cERR_W = $clog2(pDAT_W + 1);
  localparam int cRUN_W = $clog2(pLOCK_BITS + 1);
  localparam int cWIN_W = (pLOSS_WIN > 1) ? $clog2(pLOSS_WIN) : 1;
  localparam int cACC_W = $clog2(pLOSS_ERR + pDAT_W + 1);

  localparam logic [cRUN_W-1:0] cRUN_MAX  = cRUN_W'(pLOCK_BITS);
  localparam logic [cWIN_W-1:0] cWIN_LAST = cWIN_W'(pLOSS_WIN - 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_r;
  logic [22:0]         st_r;
  logic [4:0]          fill_r;
  logic [cRUN_W-1:0]   run_r;
  logic [cWIN_W-1:0]   wcnt_r;
  logic [cACC_W-1:0]   wacc_r;
  logic                oval_r;
  logic                lock_r;
  logic [cERR_W-1:0]   err_bits_r;
  logic [31:0]         err_cnt_r;
  logic [47:0]         bit_cnt_r;

  logic [pDAT_W-1:0]   ord_s;
  logic                r_s;
  logic                e_s;
  logic [22:0]         st_s;
  logic [4:0]          fill_s;
  logic [cRUN_W-1:0]   run_s;
  logic [cERR_W-1:0]   errs_s;
  logic                hit_s;
  logic [32:0]         err_sum_s;
  logic [48:0]         bit_sum_s;
  logic [31:0]         wsum_s;

  // Walk the word bit by bit; each bit's state update feeds the next bit's prediction
  always_comb begin
    if (pMSB_FIRST != 0) begin
      ord_s = {<<{bus.idat}};
    end else begin
      ord_s = bus.idat;
    end
    r_s    = 1'b0;
    e_s    = 1'b0;
    st_s   = st_r;
    fill_s = fill_r;
    run_s  = run_r;
    errs_s = {cERR_W{1'b0}};
    hit_s  = 1'b0;
    for (int k = 0; k < pDAT_W; k++) begin
      r_s   = ord_s[0];
      ord_s = ord_s >> 1'b1;
      e_s   = st_s[22] ^ st_s[17] ^ 1'b1;
      if (state_r == LOCKED) begin
        if (r_s != e_s) begin
          errs_s = errs_s + cERR_W'(1'b1);
        end else begin
          errs_s = errs_s;
        end
        // Feeding back the prediction keeps one channel error from tripling
        st_s = {st_s[21:0], e_s};
      end else begin
        if (fill_s < 5'd23) begin
          fill_s = fill_s + 5'd1;
        end else if (r_s == e_s) begin
          if (run_s < cRUN_MAX) begin
            run_s = run_s + cRUN_W'(1'b1);
          end else begin
            run_s = run_s;
          end
        end else begin
          run_s = {cRUN_W{1'b0}};
        end
        if (run_s == cRUN_MAX) begin
          hit_s = 1'b1;
        end else begin
          hit_s = hit_s;
        end
        st_s = {st_s[21:0], r_s};
      end
    end
  end

  // Saturating counter sums (clear is applied before the word's contribution) and window total
  always_comb begin
    if (bus.iclr) begin
      err_sum_s = 33'd0 + 33'(errs_s);
      bit_sum_s = 49'd0 + 49'(pDAT_W);
    end else begin
      err_sum_s = {1'b0, err_cnt_r} + 33'(errs_s);
      bit_sum_s = {1'b0, bit_cnt_r} + 49'(pDAT_W);
    end
    wsum_s = 32'(wacc_r) + 32'(errs_s);
  end

  // Lock FSM, lock monitor window and registered report outputs
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_r    <= SEARCH;
      st_r       <= 23'd0;
      fill_r     <= 5'd0;
      run_r      <= {cRUN_W{1'b0}};
      wcnt_r     <= {cWIN_W{1'b0}};
      wacc_r     <= {cACC_W{1'b0}};
      oval_r     <= 1'b0;
      lock_r     <= 1'b0;
      err_bits_r <= {cERR_W{1'b0}};
      err_cnt_r  <= 32'd0;
      bit_cnt_r  <= 48'd0;
    end else if (iclkena) begin
      oval_r <= bus.ival;
      if (bus.ival) begin
        st_r <= st_s;
        case (state_r)
          SEARCH: begin
            fill_r     <= fill_s;
            run_r      <= run_s;
            err_bits_r <= {cERR_W{1'b0}};
            if (bus.iclr) begin
              err_cnt_r <= 32'd0;
              bit_cnt_r <= 48'd0;
            end
            if (hit_s) begin
              state_r <= LOCKED;
              lock_r  <= 1'b1;
            end
          end
          LOCKED: begin
            err_bits_r <= errs_s;
            err_cnt_r  <= err_sum_s[32] ? {32{1'b1}} : err_sum_s[31:0];
            bit_cnt_r  <= bit_sum_s[48] ? {48{1'b1}} : bit_sum_s[47:0];
            if (wsum_s >= 32'(pLOSS_ERR)) begin
              state_r <= SEARCH;
              lock_r  <= 1'b0;
              fill_r  <= 5'd0;
              run_r   <= {cRUN_W{1'b0}};
              wcnt_r  <= {cWIN_W{1'b0}};
              wacc_r  <= {cACC_W{1'b0}};
            end else if (wcnt_r == cWIN_LAST) begin
              wcnt_r <= {cWIN_W{1'b0}};
              wacc_r <= {cACC_W{1'b0}};
            end else begin
              wcnt_r <= wcnt_r + cWIN_W'(1'b1);
              wacc_r <= cACC_W'(wsum_s);
            end
          end
          default: begin
            state_r <= SEARCH;
            lock_r  <= 1'b0;
          end
        endcase
      end else if (bus.iclr) begin
        err_cnt_r <= 32'd0;
        bit_cnt_r <= 48'd0;
      end
    end
  end

  assign bus.oval      = oval_r;
  assign bus.olock     = lock_r;
  assign bus.oerr_bits = err_bits_r;
  assign bus.oerr_cnt  = err_cnt_r;
  assign bus.obit_cnt  = bit_cnt_r;

endmodule

// File: tb/tb_prbs_chk23.sv
// Scoreboard bench for prbs_chk23: a queue-based PRBS23 generator and a checker reference model
// push expected results, and a monitor pops and compares them on every DUT output word.
module tb_prbs_chk23;
  localparam int W         = 8;
  localparam int LOCK_BITS = 64;
  localparam int LOSS_WIN  = 16;
  localparam int LOSS_ERR  = 32;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX48 = 64'h0000_FFFF_FFFF_FFFF;

  logic iclk = 1'b0;
  logic ireset;
  logic iclkena;

  prbs_chk23_if #(.pDAT_W(W)) bus ();

  prbs_chk23 #(
    .pDAT_W(W), .pMSB_FIRST(0), .pLOCK_BITS(LOCK_BITS),
    .pLOSS_WIN(LOSS_WIN), .pLOSS_ERR(LOSS_ERR)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .bus(bus)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    bit     lock;
    int     errb;
    longint ecnt;
    longint bcnt;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   exp_last;
  bit     exp_oval;
  int     checks = 0;
  int     errors = 0;
  int     words_out;
  int     lock_at;
  int     drop_at;
  bit     lock_prev;

  // Generator and model histories: element 0 is the oldest bit (s[23]), element 5 is s[18]
  bit     gen[$];
  bit     hist[$];
  bit     m_locked;
  int     m_fill, m_run, m_wcnt, m_wacc;
  longint m_ecnt, m_bcnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gen_word();
    logic [W-1:0] w;
    bit b;
    for (int k = 0; k < W; k++) begin
      b = gen[0] ^ gen[5] ^ 1'b1;
      gen.push_back(b);
      void'(gen.pop_front());
      w[k] = b;
    end
    return w;
  endfunction

  task automatic model_reset();
    gen.delete();
    hist.delete();
    for (int k = 0; k < 23; k++) begin
      gen.push_back(1'b0);
      hist.push_back(1'b0);
    end
    m_locked = 1'b0;
    m_fill = 0; m_run = 0; m_wcnt = 0; m_wacc = 0;
    m_ecnt = 0; m_bcnt = 0;
  endtask

  // Reference model: apply the checker rules to one accepted word and queue the expected report
  task automatic model_word(input logic [W-1:0] d, input bit clr);
    exp_t x;
    int   errs = 0;
    bit   hit = 1'b0;
    bit   was = m_locked;
    bit   r, e;
    for (int k = 0; k < W; k++) begin
      r = d[k];
      e = hist[0] ^ hist[5] ^ 1'b1;
      if (was) begin
        if (r != e) errs++;
        hist.push_back(e);
      end else begin
        if (m_fill < 23) m_fill++;
        else if (r == e) m_run = (m_run < LOCK_BITS) ? m_run + 1 : m_run;
        else m_run = 0;
        if (m_run == LOCK_BITS) hit = 1'b1;
        hist.push_back(r);
      end
      void'(hist.pop_front());
    end
    if (clr) begin
      m_ecnt = 0;
      m_bcnt = 0;
    end
    if (was) begin
      m_ecnt = (m_ecnt + errs > MAX32) ? MAX32 : m_ecnt + errs;
      m_bcnt = (m_bcnt + W > MAX48) ? MAX48 : m_bcnt + W;
      if (m_wacc + errs >= LOSS_ERR) begin
        m_locked = 1'b0;
        m_fill = 0; m_run = 0; m_wcnt = 0; m_wacc = 0;
      end else if (m_wcnt == LOSS_WIN - 1) begin
        m_wcnt = 0; m_wacc = 0;
      end else begin
        m_wcnt++;
        m_wacc += errs;
      end
    end else if (hit) begin
      m_locked = 1'b1;
    end
    x.lock = m_locked;
    x.errb = was ? errs : 0;
    x.ecnt = m_ecnt;
    x.bcnt = m_bcnt;
    exp_q.push_back(x);
  endtask

  // Drive one cycle at the falling edge; the model advances only on accepted words
  task automatic cycle(input bit en, input bit val, input logic [W-1:0] d, input bit clr);
    iclkena  = en;
    bus.ival = val;
    bus.idat = d;
    bus.iclr = clr;
    if (en && val) model_word(d, clr);
    @(negedge iclk);
  endtask

  task automatic send(input logic [W-1:0] d, input bit clr);
    cycle(1'b1, 1'b1, d, clr);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_oval"}, bus.oval, 0);
    chk({tag, "_olock"}, bus.olock, 0);
    chk({tag, "_oerr_bits"}, bus.oerr_bits, 0);
    chk({tag, "_oerr_cnt"}, bus.oerr_cnt, 0);
    chk({tag, "_obit_cnt"}, bus.obit_cnt, 0);
  endtask

  task automatic tb_clear_expect();
    exp_last  = '{lock: 1'b0, errb: 0, ecnt: 0, bcnt: 0};
    exp_oval  = 1'b0;
    words_out = 0;
    lock_at   = -1;
    lock_prev = 1'b0;
  endtask

  // Monitor: pop on each accepted word, otherwise expect oval low (enabled) or frozen outputs
  initial begin
    bit acc, en;
    forever begin
      @(posedge iclk);
      acc = iclkena && bus.ival && !ireset;
      en  = iclkena;
      @(negedge iclk);
      if (ireset) continue;
      if (acc) begin
        if (exp_q.size() == 0) begin
          chk("queue_empty", 1, 0);
          continue;
        end
        exp_last = exp_q.pop_front();
        exp_oval = 1'b1;
        words_out++;
        if (bus.olock && lock_at < 0) lock_at = words_out;
        if (lock_prev && !bus.olock && drop_at < 0) drop_at = words_out;
        lock_prev = bus.olock;
      end else if (en) begin
        exp_oval = 1'b0;
      end
      chk("oval", bus.oval, exp_oval);
      chk("olock", bus.olock, exp_last.lock);
      chk("oerr_bits", bus.oerr_bits, exp_last.errb);
      chk("oerr_cnt", bus.oerr_cnt, exp_last.ecnt);
      chk("obit_cnt", bus.obit_cnt, exp_last.bcnt);
    end
  end

  initial begin
    int sent;
    int loss_start;
    drop_at  = -1;
    ireset   = 1'b1;
    iclkena  = 1'b0;
    bus.ival = 1'b0;
    bus.idat = '0;
    bus.iclr = 1'b0;
    model_reset();
    tb_clear_expect();
    #1;
    check_zero_outputs("reset");
    @(negedge iclk);
    @(negedge iclk);
    ireset = 1'b0;

    // Continuous acquisition from generator state 0
    for (int i = 0; i < 40; i++) send(gen_word(), 1'b0);
    idle();
    chk("lock_word_continuous", lock_at, 11);
    chk("bits_after_lock", bus.obit_cnt, 8 * 29);
    chk("no_errors_after_lock", bus.oerr_cnt, 0);

    // Single channel error on bit 3
    send(gen_word() ^ 8'h08, 1'b0);
    for (int i = 0; i < 5; i++) send(gen_word(), 1'b0);
    idle();
    chk("single_error_cnt", bus.oerr_cnt, 1);
    chk("single_error_lock", bus.olock, 1);

    // Counter clear together with a clean locked word
    send(gen_word(), 1'b1);
    idle();
    chk("clear_err_cnt", bus.oerr_cnt, 0);
    chk("clear_bit_cnt", bus.obit_cnt, 8);

    // Preload the error counter near full scale, then run three errors per word
    #1;
    force dut.err_cnt_r = 32'hFFFF_FFF0;
    m_ecnt        = 64'h0000_0000_FFFF_FFF0;
    exp_last.ecnt = 64'h0000_0000_FFFF_FFF0;
    #1;
    release dut.err_cnt_r;
    @(negedge iclk);
    for (int i = 0; i < 8; i++) send(gen_word() ^ 8'h07, 1'b0);
    for (int i = 0; i < 3; i++) send(gen_word(), 1'b0);
    idle();
    chk("saturated_err_cnt", bus.oerr_cnt, MAX32);
    chk("saturated_lock", bus.olock, 1);

    // Asynchronous reset away from any clock edge while locked
    idle();
    #2;
    ireset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    exp_q.delete();
    model_reset();
    tb_clear_expect();
    @(negedge iclk);
    ireset = 1'b0;

    // Acquisition with random valid gaps and clock-enable holds
    sent = 0;
    for (int c = 0; c < 2000 && sent < 40; c++) begin
      bit en, val;
      en  = ($urandom_range(0, 3) != 0);
      val = ($urandom_range(0, 2) != 0);
      if (en && val) begin
        cycle(1'b1, 1'b1, gen_word(), 1'b0);
        sent++;
      end else begin
        cycle(en, val, 8'($urandom), 1'b0);
      end
    end
    idle();
    chk("flow_words_sent", sent, 40);
    chk("lock_word_flow", lock_at, 11);

    // Loss of lock: constant zeros never relock
    loss_start = words_out;
    drop_at    = -1;
    for (int i = 0; i < 40; i++) send(8'h00, 1'b0);
    idle();
    chk("loss_seen", (drop_at > loss_start) ? 1 : 0, 1);
    chk("loss_within_window", (drop_at - loss_start <= LOSS_WIN) ? 1 : 0, 1);
    chk("lock_after_loss", bus.olock, 0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_chk23.md
# prbs_chk23

Receive-side checker for the x^23 + x^18 + 1 PRBS stream produced by the team's PRBS23 generator (inverted-feedback form: each bit = s[23] ^ s[18] ^ 1, shifted into a 23-bit state). It sits at the demodulator/decoder output in BER-test mode. It self-synchronises to the incoming stream, declares lock, and then free-runs a local reference. It reports per-word bit errors and cumulative error and bit counts for BER measurement.

## Interface
- pDAT_W, 1: bits per input word.
- pMSB_FIRST, 0: 1/0 :: first received bit of a word is MSB/LSB; must match the generator setting.
- pLOCK_BITS, 64: consecutive correctly predicted bits required to declare lock.
- pLOSS_WIN, 16: lock-monitor window length, in valid words.
- pLOSS_ERR, 32: bit errors within one window that force loss of lock.

Ports:
- iclk  in  1  clock.
- ireset  in  1  asynchronous reset, active-high.
- iclkena  in  1  clock enable; when low, all state and outputs hold.
- ival  in  1  input word valid.
- idat  in  pDAT_W  received word.
- iclr  in  1  synchronous clear of oerr_cnt and obit_cnt (qualified by iclkena).
- oval  out  1  output word valid.
- olock  out  1  checker locked.
- oerr_bits  out  $clog2(pDAT_W+1)  erroneous bits in the last word (0 when unlocked).
- oerr_cnt  out  32  saturating bit-error count while locked.
- obit_cnt  out  48  saturating count of bits checked while locked.

## Operation
- Prediction per bit: e = st[23] ^ st[18] ^ 1. Mismatch when received bit r != e.
- Bits within a word are processed sequentially, in the order set by pMSB_FIRST. The state update of bit k feeds the prediction of bit k+1 in the same cycle.
- The FSM has two states, SEARCH and LOCKED. It resets to SEARCH with st = 0, fill = 0 and run = 0.
- SEARCH: st = (st << 1) | r (self-synchronising).
  - While fill < 23, fill increments and the bit is not checked.
  - Once fill == 23, a match increments run and a mismatch clears run to 0.
  - When run reaches pLOCK_BITS at any bit of a word, the FSM enters LOCKED for the next word.
  - The remaining bits of that word are still processed in SEARCH rules.
  - Errors are not counted in SEARCH.
- LOCKED: st = (st << 1) | e (free-running). A single channel bit error therefore counts once, not three times.
  - oerr_bits = number of mismatches in the word.
  - oerr_cnt += oerr_bits and obit_cnt += pDAT_W, both saturating at all-ones.
  - Lock monitor: wcnt counts valid words 0..pLOSS_WIN-1 and wacc accumulates errors.
  - If wacc + oerr_bits >= pLOSS_ERR, the FSM goes to SEARCH next word, with fill, run, wcnt and wacc all cleared. The st register is kept, but is overwritten by received bits.
  - Otherwise, at wcnt == pLOSS_WIN-1, wcnt and wacc clear.
- iclr clears both counters. If iclr and a valid word occur in the same cycle, the result is that word's contribution only (clear first, then add).
- An all-zeros input never locks, because the prediction is always 1.

## Timing
- Reset values: oval=0, olock=0, oerr_bits=0, oerr_cnt=0, obit_cnt=0. Internal state as above.
- Latency is 1 cycle. A word accepted on edge n (iclkena & ival) gives oval=1 after edge n with its oerr_bits. oval is otherwise 0 (registered pulse per valid word).
- olock updates on the same edge as oval of the word that completes lock or loss. The word that causes loss still reports its errors and is counted.
- iclkena=0: no state change, outputs hold, including oval.
- ival=0 with iclkena=1: oval goes to 0 and all other state holds. Gaps do not affect lock.
- ireset mid-operation: immediate return to reset values regardless of iclk or iclkena.

## Test plan
- Reset: assert ireset while mid-LOCKED -> all outputs 0 asynchronously; after release, SEARCH with fill=0.
- Acquisition: pDAT_W=8, pMSB_FIRST=0, drive generator output (generator state 0, continuous ival) -> olock=1 together with oval of word 11 (23+64=87 bits); oerr_cnt=0 and obit_cnt=8*N for N subsequent words.
- Single error: once locked, invert bit 3 of one word -> oerr_bits=1 for that word only; oerr_cnt=1; olock stays 1.
- Loss of lock: once locked, drive idat=8'h00 continuously -> olock falls within 16 words and never reasserts; oerr_cnt stops increasing after the drop.
- Flow control: random ival gaps and iclkena low periods during acquisition -> same lock word index as the continuous case; outputs frozen while iclkena=0.
- Clear and saturation: pulse iclr while locked -> counters show only the current word's contribution. Force oerr_cnt near 2^32-1 with a high error rate -> holds at 32'hFFFF_FFFF.
